zoom_frame_seq: RTL and testbench
=================================

Name: zoom_frame_seq

Overview:
- Frame sequencer between the upstream pixel FIFO and the 2x2 window generator of the bilinear zoom path.
- The window generator has no busy flag and must be cleared between frames. This block admits exactly one complete H_ACT x V_ACT frame per vertical sync.
- It drives the generator's clear, forwards pixels with a 1-cycle registered latency, drains the pipeline, and reports frame completion and aborted frames.

Parameters:
H_ACT, 1280, active pixels per line
V_ACT, 720, active lines per frame
CLR_CYC, 2, cycles mtx_clr is held high before a frame is admitted (>=1)
DRAIN_CYC, 3, cycles waited after the last forwarded pixel before frame_done (generator latency)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
zoom_en  in  1  enable; sampled only in IDLE/DONE
vs_in  in  1  vertical sync from the source, active high; rising edge = frame start
src_vld  in  1  upstream pixel valid
src_data  in  16  upstream RGB565 pixel
src_rdy  out  1  upstream ready; a transfer occurs when src_vld & src_rdy
mtx_clr  out  1  active-high clear to the window generator (its vga_vs input)
mtx_vld  out  1  pixel valid to the window generator
mtx_din  out  16  pixel to the window generator
busy  out  1  high in CLEAR, ACTIVE and DRAIN
frame_done  out  1  one-cycle pulse when a full frame has been drained
err_short  out  1  one-cycle pulse when a frame is aborted by an early vs edge
col_cnt  out  11  column of the next pixel to accept, 0..H_ACT-1
row_cnt  out  10  line of the next pixel to accept, 0..V_ACT-1
frame_cnt  out  8  completed frames, wraps 255->0

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, mtx_clr=1, src_rdy=0, mtx_vld=0, mtx_din=0, busy=0, frame_done=0, err_short=0, col_cnt=0, row_cnt=0, frame_cnt=0, pending=0.
- vs edge register vs_d resets to 1, so a vs_in already high at reset release is not treated as an edge.
- vs_edge = vs_in & ~vs_d.
- All outputs are registered.
- States:
  - IDLE: mtx_clr=1, src_rdy=0. On (vs_edge | pending) & zoom_en -> CLEAR, and clear pending.
  - CLEAR: mtx_clr=1. Load the down-counter with CLR_CYC-1; at 0 -> ACTIVE. Counters are zeroed on entry.
  - ACTIVE: mtx_clr=0, src_rdy=1.
    - On each transfer, in the next cycle: mtx_vld=1 and mtx_din=src_data. Otherwise mtx_vld=0 and mtx_din holds its value.
    - col_cnt increments per transfer and wraps at H_ACT-1 to 0, incrementing row_cnt.
    - The transfer at col=H_ACT-1, row=V_ACT-1 -> DRAIN. src_rdy drops in the cycle after that transfer; no further transfer is accepted.
  - DRAIN: src_rdy=0, mtx_clr=0. Wait DRAIN_CYC cycles -> DONE.
  - DONE: one cycle. frame_done=1, frame_cnt+1. If (vs_edge | pending) & zoom_en -> CLEAR, else -> IDLE.
- Abort: a vs_edge in ACTIVE (frame incomplete) gives err_short=1 for one cycle and -> CLEAR. mtx_clr rises next cycle, counters zero, frame_cnt is unchanged, no frame_done.
- A vs_edge in CLEAR restarts the CLEAR count.
- A vs_edge in DRAIN sets pending=1. It is serviced in DONE.
- Last-pixel transfer and vs_edge in the same cycle: the frame is complete -> DRAIN, and pending=1. No err_short.
- zoom_en low in ACTIVE/DRAIN: the current frame finishes normally. IDLE is then held until zoom_en=1 and an edge occurs.
- A pending flag set while zoom_en=0 survives until zoom_en=1 or rst.
- src_vld low in ACTIVE: counters hold. There is no timeout.
- rst mid-frame returns all state to the reset values within the same edge. Since the post-reset mtx_clr=1, the window generator is also cleared.

Test Plan:
1. H_ACT=8, V_ACT=4, zoom_en=1, vs edge, src_vld held 1 -> mtx_clr low after 2 cycles, 32 mtx_vld pulses each 1 cycle after transfer with data matching, frame_done exactly 3 cycles after the last mtx_vld, frame_cnt=1.
2. Same config, src_vld toggling 1/0 with random data -> 32 transfers in order, col_cnt/row_cnt wrap at 7/3, no pixel duplicated or dropped.
3. vs edge after 13 transfers -> err_short pulse, mtx_clr=1 next cycle, col_cnt=0, row_cnt=0, a fresh 32-pixel frame completes, frame_cnt=1.
4. vs edge in the same cycle as the 32nd transfer -> no err_short, frame_done, then DONE->CLEAR directly, and a second frame completes with frame_cnt=2.
5. zoom_en dropped mid-frame -> frame completes, frame_done pulses, then IDLE with src_rdy=0 while further vs edges are ignored.
6. rst asserted for 1 cycle at transfer 20, vs_in held high -> all outputs return to reset values, no spurious frame start until vs_in falls and rises again.

Source files
------------

// File: rtl/zoom_frame_seq.sv
// Frame sequencer for the bilinear zoom path: admits one H_ACT x V_ACT frame per
// vertical sync, clears the 2x2 window generator between frames and drains it afterwards.
module zoom_frame_seq #(
    parameter int H_ACT     = 1280,
    parameter int V_ACT     = 720,
    parameter int CLR_CYC   = 2,
    parameter int DRAIN_CYC = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        zoom_en,
    input  logic        vs_in,
    input  logic        src_vld,
    input  logic [15:0] src_data,
    output logic        src_rdy,
    output logic        mtx_clr,
    output logic        mtx_vld,
    output logic [15:0] mtx_din,
    output logic        busy,
    output logic        frame_done,
    output logic        err_short,
    output logic [10:0] col_cnt,
    output logic [9:0]  row_cnt,
    output logic [7:0]  frame_cnt
);

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_ACTIVE, S_DRAIN, S_DONE} state_t;

    state_t     state;
    logic       vs_d;
    logic       pending;
    logic [7:0] dly_cnt;

    logic vs_edge;
    logic xfer;
    logic last_px;
    logic start_req;

    assign vs_edge   = vs_in & ~vs_d;
    assign xfer      = src_vld & src_rdy;
    assign last_px   = (col_cnt == 11'(H_ACT - 1)) && (row_cnt == 10'(V_ACT - 1));
    assign start_req = (vs_edge | pending) & zoom_en;

    // Every output is registered, so each branch assigns the values of the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            vs_d       <= 1'b1;
            pending    <= 1'b0;
            dly_cnt    <= '0;
            mtx_clr    <= 1'b1;
            src_rdy    <= 1'b0;
            mtx_vld    <= 1'b0;
            mtx_din    <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            err_short  <= 1'b0;
            col_cnt    <= '0;
            row_cnt    <= '0;
            frame_cnt  <= '0;
        end else begin
            vs_d       <= vs_in;
            mtx_vld    <= 1'b0;
            frame_done <= 1'b0;
            err_short  <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (start_req) begin
                        state   <= S_CLEAR;
                        pending <= 1'b0;
                        busy    <= 1'b1;
                        dly_cnt <= 8'(CLR_CYC - 1);
                        col_cnt <= '0;
                        row_cnt <= '0;
                    end
                end

                S_CLEAR: begin
                    if (vs_edge) begin
                        dly_cnt <= 8'(CLR_CYC - 1);
                    end else if (dly_cnt == '0) begin
                        state   <= S_ACTIVE;
                        mtx_clr <= 1'b0;
                        src_rdy <= 1'b1;
                    end else begin
                        dly_cnt <= dly_cnt - 8'd1;
                    end
                end

                S_ACTIVE: begin
                    if (xfer && last_px) begin
                        // A sync edge on the last pixel still completes the frame; it is queued.
                        state   <= S_DRAIN;
                        src_rdy <= 1'b0;
                        mtx_vld <= 1'b1;
                        mtx_din <= src_data;
                        dly_cnt <= 8'(DRAIN_CYC - 1);
                        col_cnt <= '0;
                        row_cnt <= '0;
                        if (vs_edge)
                            pending <= 1'b1;
                    end else if (vs_edge) begin
                        state     <= S_CLEAR;
                        err_short <= 1'b1;
                        mtx_clr   <= 1'b1;
                        src_rdy   <= 1'b0;
                        dly_cnt   <= 8'(CLR_CYC - 1);
                        col_cnt   <= '0;
                        row_cnt   <= '0;
                    end else if (xfer) begin
                        mtx_vld <= 1'b1;
                        mtx_din <= src_data;
                        if (col_cnt == 11'(H_ACT - 1)) begin
                            col_cnt <= '0;
                            row_cnt <= row_cnt + 10'd1;
                        end else begin
                            col_cnt <= col_cnt + 11'd1;
                        end
                    end
                end

                S_DRAIN: begin
                    if (vs_edge)
                        pending <= 1'b1;
                    if (dly_cnt == '0) begin
                        state      <= S_DONE;
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                        frame_cnt  <= frame_cnt + 8'd1;
                    end else begin
                        dly_cnt <= dly_cnt - 8'd1;
                    end
                end

                S_DONE: begin
                    mtx_clr <= 1'b1;
                    if (start_req) begin
                        state   <= S_CLEAR;
                        pending <= 1'b0;
                        busy    <= 1'b1;
                        dly_cnt <= 8'(CLR_CYC - 1);
                        col_cnt <= '0;
                        row_cnt <= '0;
                    end else begin
                        state <= S_IDLE;
                    end
                end

                default: begin
                    state   <= S_IDLE;
                    mtx_clr <= 1'b1;
                    src_rdy <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_zoom_frame_seq.sv
// Directed bench for zoom_frame_seq on an 8x4 frame: a per-cycle vector table for
// start-up and abort, then hand-written frame sequences for the multi-cycle cases.
module tb_zoom_frame_seq;

    localparam int HA = 8;
    localparam int VA = 4;

    logic        clk;
    logic        rst;
    logic        zoom_en;
    logic        vs_in;
    logic        src_vld;
    logic [15:0] src_data;
    logic        src_rdy;
    logic        mtx_clr;
    logic        mtx_vld;
    logic [15:0] mtx_din;
    logic        busy;
    logic        frame_done;
    logic        err_short;
    logic [10:0] col_cnt;
    logic [9:0]  row_cnt;
    logic [7:0]  frame_cnt;

    zoom_frame_seq #(.H_ACT(HA), .V_ACT(VA), .CLR_CYC(2), .DRAIN_CYC(3)) dut (
        .clk(clk), .rst(rst), .zoom_en(zoom_en), .vs_in(vs_in),
        .src_vld(src_vld), .src_data(src_data), .src_rdy(src_rdy),
        .mtx_clr(mtx_clr), .mtx_vld(mtx_vld), .mtx_din(mtx_din),
        .busy(busy), .frame_done(frame_done), .err_short(err_short),
        .col_cnt(col_cnt), .row_cnt(row_cnt), .frame_cnt(frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        rst;
        logic        zen;
        logic        vs;
        logic        vld;
        logic [15:0] d;
    } ins_t;

    typedef struct packed {
        logic        clr;
        logic        rdy;
        logic        mv;
        logic [15:0] din;
        logic        busy;
        logic        fd;
        logic        er;
        logic [10:0] col;
        logic [9:0]  row;
        logic [7:0]  fc;
    } outs_t;

    typedef struct {
        ins_t  i;
        outs_t o;
    } vec_t;

    vec_t tv[$];
    int   nv;
    int   nf;
    int   nx;
    int   tag;

    function automatic ins_t mi(logic r, logic z, logic v, logic s, logic [15:0] d);
        return '{r, z, v, s, d};
    endfunction

    function automatic outs_t mo(logic c, logic r, logic v, logic [15:0] d, logic b,
                                 logic e, logic [10:0] col);
        return '{c, r, v, d, b, 1'b0, e, col, 10'd0, 8'd0};
    endfunction

    function automatic outs_t sample();
        return '{mtx_clr, src_rdy, mtx_vld, mtx_din, busy, frame_done, err_short,
                 col_cnt, row_cnt, frame_cnt};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int got, input int want);
        nv++;
        if (got != want) begin
            nf++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, got, got, want, want);
        end
    endtask

    task automatic cmp_outs(input string nm, input outs_t w);
        outs_t g;
        g = sample();
        nv++;
        if (g !== w) begin
            nf++;
            $display("FAIL %s: got clr=%b rdy=%b vld=%b din=%h busy=%b done=%b err=%b col=%0d row=%0d fcnt=%0d | expected clr=%b rdy=%b vld=%b din=%h busy=%b done=%b err=%b col=%0d row=%0d fcnt=%0d",
                     nm, g.clr, g.rdy, g.mv, g.din, g.busy, g.fd, g.er, g.col, g.row, g.fc,
                     w.clr, w.rdy, w.mv, w.din, w.busy, w.fd, w.er, w.col, w.row, w.fc);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; zoom_en = 1'b1; vs_in = 1'b0; src_vld = 1'b0; src_data = '0;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic enter_active(input string nm);
        tick();
        chk({nm, "_clr_hold"}, int'(mtx_clr), 1);
        chk({nm, "_rdy_hold"}, int'(src_rdy), 0);
        tick();
        chk({nm, "_clr_low"}, int'(mtx_clr), 0);
        chk({nm, "_rdy_high"}, int'(src_rdy), 1);
        nx = 0;
    endtask

    task automatic start_frame(input string nm);
        vs_in = 1'b1;
        tick();
        chk({nm, "_clear_busy"}, int'(busy), 1);
        chk({nm, "_clear_clr"}, int'(mtx_clr), 1);
        vs_in = 1'b0;
        enter_active(nm);
    endtask

    // Streams pixels until nx transfers have been made this frame.
    task automatic stream(input string nm, input int upto, input bit toggle, input bit rnd);
        int   guard;
        bit   ph;
        bit   pend;
        logic [15:0] sent;
        guard = 0;
        ph    = 1'b1;
        while (nx < upto && guard < 400) begin
            src_vld  = toggle ? ph : 1'b1;
            ph       = ~ph;
            src_data = rnd ? 16'($urandom) : 16'(tag * 256 + nx);
            pend     = src_vld & src_rdy;
            sent     = src_data;
            tick();
            if (pend) nx++;
            chk({nm, "_vld_lat"}, int'(mtx_vld), int'(pend));
            if (pend) chk({nm, "_din"}, int'(mtx_din), int'(sent));
            chk({nm, "_col"}, int'(col_cnt), nx % HA);
            chk({nm, "_row"}, int'(row_cnt), (nx / HA) % VA);
            guard++;
        end
        if (guard >= 400) chk({nm, "_stream_timeout"}, nx, upto);
        src_vld = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int lat, input int fc);
        int k;
        for (k = 1; k <= 20; k++) begin
            tick();
            if (frame_done) break;
        end
        chk({nm, "_done_lat"}, k, lat);
        chk({nm, "_fcnt"}, int'(frame_cnt), fc);
    endtask

    initial begin
        nv = 0; nf = 0; nx = 0; tag = 8'hA0;
        rst = 1'b1; zoom_en = 1'b1; vs_in = 1'b0; src_vld = 1'b0; src_data = '0;

        tv.push_back('{mi(1, 1, 0, 0, 16'h0000), mo(1, 0, 0, 16'h0000, 0, 0, 11'd0)});
        tv.push_back('{mi(0, 0, 0, 0, 16'h0000), mo(1, 0, 0, 16'h0000, 0, 0, 11'd0)});
        tv.push_back('{mi(0, 0, 1, 0, 16'h0000), mo(1, 0, 0, 16'h0000, 0, 0, 11'd0)});
        tv.push_back('{mi(0, 1, 1, 0, 16'h0000), mo(1, 0, 0, 16'h0000, 0, 0, 11'd0)});
        tv.push_back('{mi(0, 1, 0, 0, 16'h0000), mo(1, 0, 0, 16'h0000, 0, 0, 11'd0)});
        tv.push_back('{mi(0, 1, 1, 0, 16'h0000), mo(1, 0, 0, 16'h0000, 1, 0, 11'd0)});
        tv.push_back('{mi(0, 1, 1, 0, 16'h0000), mo(1, 0, 0, 16'h0000, 1, 0, 11'd0)});
        tv.push_back('{mi(0, 1, 1, 1, 16'h1111), mo(0, 1, 0, 16'h0000, 1, 0, 11'd0)});
        tv.push_back('{mi(0, 1, 1, 1, 16'hA001), mo(0, 1, 1, 16'hA001, 1, 0, 11'd1)});
        tv.push_back('{mi(0, 1, 1, 0, 16'hFFFF), mo(0, 1, 0, 16'hA001, 1, 0, 11'd1)});
        tv.push_back('{mi(0, 1, 1, 1, 16'hA002), mo(0, 1, 1, 16'hA002, 1, 0, 11'd2)});
        tv.push_back('{mi(0, 1, 0, 1, 16'hA003), mo(0, 1, 1, 16'hA003, 1, 0, 11'd3)});
        tv.push_back('{mi(0, 1, 0, 1, 16'hA004), mo(0, 1, 1, 16'hA004, 1, 0, 11'd4)});
        tv.push_back('{mi(0, 1, 1, 0, 16'hA005), mo(1, 0, 0, 16'hA004, 1, 1, 11'd0)});
        tv.push_back('{mi(0, 1, 1, 1, 16'hB000), mo(1, 0, 0, 16'hA004, 1, 0, 11'd0)});
        tv.push_back('{mi(0, 1, 0, 1, 16'hB001), mo(0, 1, 0, 16'hA004, 1, 0, 11'd0)});
        tv.push_back('{mi(0, 1, 0, 1, 16'hB002), mo(0, 1, 1, 16'hB002, 1, 0, 11'd1)});

        foreach (tv[i]) begin
            rst = tv[i].i.rst; zoom_en = tv[i].i.zen; vs_in = tv[i].i.vs;
            src_vld = tv[i].i.vld; src_data = tv[i].i.d;
            tick();
            cmp_outs($sformatf("vec%0d", i), tv[i].o);
        end

        // 1: full frame, src_vld held high
        do_reset();
        tag = 8'h10;
        start_frame("t1");
        stream("t1", HA * VA, 1'b0, 1'b0);
        chk("t1_rdy_drop", int'(src_rdy), 0);
        wait_done("t1", 3, 1);
        tick();
        chk("t1_done_pulse", int'(frame_done), 0);
        chk("t1_idle_busy", int'(busy), 0);
        chk("t1_idle_clr", int'(mtx_clr), 1);

        // 2: toggling valid, random data
        start_frame("t2");
        stream("t2", HA * VA, 1'b1, 1'b1);
        wait_done("t2", 3, 2);
        tick();

        // 3: early sync after 13 transfers aborts the frame
        do_reset();
        tag = 8'h30;
        start_frame("t3");
        stream("t3", 13, 1'b0, 1'b0);
        vs_in = 1'b1;
        tick();
        chk("t3_err", int'(err_short), 1);
        chk("t3_abort_clr", int'(mtx_clr), 1);
        chk("t3_abort_col", int'(col_cnt), 0);
        chk("t3_abort_row", int'(row_cnt), 0);
        chk("t3_abort_nodone", int'(frame_done), 0);
        vs_in = 1'b0;
        tick();
        chk("t3_err_pulse", int'(err_short), 0);
        chk("t3_clear_clr", int'(mtx_clr), 1);
        tick();
        chk("t3_active_rdy", int'(src_rdy), 1);
        nx = 0;
        stream("t3b", HA * VA, 1'b0, 1'b0);
        wait_done("t3", 3, 1);
        tick();

        // 4: sync edge coincident with the last transfer
        do_reset();
        tag = 8'h40;
        start_frame("t4");
        stream("t4", HA * VA - 1, 1'b0, 1'b0);
        src_vld = 1'b1; vs_in = 1'b1; src_data = 16'(tag * 256 + nx);
        tick();
        chk("t4_last_vld", int'(mtx_vld), 1);
        chk("t4_last_din", int'(mtx_din), tag * 256 + HA * VA - 1);
        chk("t4_no_err", int'(err_short), 0);
        chk("t4_rdy_drop", int'(src_rdy), 0);
        src_vld = 1'b0; vs_in = 1'b0;
        wait_done("t4", 3, 1);
        tick();
        chk("t4_done_to_clear", int'(busy), 1);
        chk("t4_clear_clr", int'(mtx_clr), 1);
        enter_active("t4b");
        stream("t4b", HA * VA, 1'b0, 1'b0);
        wait_done("t4b", 3, 2);
        tick();

        // 5: zoom_en dropped mid-frame
        do_reset();
        tag = 8'h50;
        start_frame("t5");
        stream("t5", 10, 1'b0, 1'b0);
        zoom_en = 1'b0;
        stream("t5", HA * VA, 1'b0, 1'b0);
        wait_done("t5", 3, 1);
        tick();
        chk("t5_idle_busy", int'(busy), 0);
        chk("t5_idle_rdy", int'(src_rdy), 0);
        for (int i = 0; i < 3; i++) begin
            vs_in = 1'b1;
            tick();
            chk("t5_ign_busy", int'(busy), 0);
            vs_in = 1'b0;
            tick();
            chk("t5_ign_rdy", int'(src_rdy), 0);
        end
        zoom_en = 1'b1;
        tick();
        chk("t5_no_pending", int'(busy), 0);

        // 6: reset at transfer 20 with vs_in held high
        tag = 8'h60;
        start_frame("t6");
        stream("t6", 20, 1'b0, 1'b0);
        rst = 1'b1; vs_in = 1'b1; src_vld = 1'b1;
        tick();
        cmp_outs("t6_reset", mo(1, 0, 0, 16'h0000, 0, 0, 11'd0));
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t6_no_start", int'(busy), 0);
        end
        src_vld = 1'b0; vs_in = 1'b0;
        tick();
        vs_in = 1'b1;
        tick();
        chk("t6_restart", int'(busy), 1);
        vs_in = 1'b0;

        // 7: sync edge in DRAIN while disabled is held until zoom_en returns
        do_reset();
        tag = 8'h70;
        start_frame("t7");
        stream("t7", HA * VA, 1'b0, 1'b0);
        zoom_en = 1'b0; vs_in = 1'b1;
        tick();
        vs_in = 1'b0;
        wait_done("t7", 2, 1);
        tick();
        chk("t7_idle", int'(busy), 0);
        tick();
        chk("t7_hold", int'(busy), 0);
        zoom_en = 1'b1;
        tick();
        chk("t7_pending_start", int'(busy), 1);

        $display("== %0d vectors applied, %0d miscompares ==", nv, nf);
        $finish;
    end

endmodule
